// File: rtl/uart_result_sender.sv
// uart_result_sender: formats the SAD match result as ASCII and sends it as 8N1 UART.
// The state counters run one cycle ahead of TX, which is registered from them.
// This gives the one-cycle accept-to-start-bit latency with no extra timing state.
module uart_result_sender #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] UARTsend,
  input  logic [8:0] currentRow,
  output logic       TX,
  output logic       busy,
  output logic       UARTsendComplete
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [1:0]  code_q, code_d;
  logic [8:0]  row_q, row_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic        baud_tc;
  logic        is_match;
  logic [2:0]  last_byte;
  logic [9:0]  row_ext, q10, q100, units, tens;
  logic [7:0]  cur_byte;

  assign is_match  = (code_q == 2'd1);
  assign last_byte = is_match ? 3'd5 : 3'd2;
  assign baud_tc   = (baud_q == BAUD_LAST);
  // busy_q is still high in the completion cycle, so a request seen then is dropped.
  assign accept    = (state_q == S_IDLE) && !busy_q &&
                     ((UARTsend == 2'd1) || (UARTsend == 2'd2));

  // Decimal digits of the latched row, settled long before the hundreds byte is sent.
  always_comb begin
    row_ext = {1'b0, row_q};
    q10     = row_ext / 10'd10;
    q100    = row_ext / 10'd100;
    units   = row_ext - q10 * 10'd10;
    tens    = q10 - q100 * 10'd10;
  end

  // Select the message byte currently being shifted out.
  always_comb begin
    cur_byte = 8'h0A;
    if (is_match) begin
      case (byte_q)
        3'd0:    cur_byte = 8'h4D;
        3'd1:    cur_byte = 8'(10'd48 + q100);
        3'd2:    cur_byte = 8'(10'd48 + tens);
        3'd3:    cur_byte = 8'(10'd48 + units);
        3'd4:    cur_byte = 8'h0D;
        default: cur_byte = 8'h0A;
      endcase
    end else begin
      case (byte_q)
        3'd0:    cur_byte = 8'h4E;
        3'd1:    cur_byte = 8'h0D;
        default: cur_byte = 8'h0A;
      endcase
    end
  end

  // Next-state, counter and output computation.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    code_d  = code_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          code_d  = UARTsend;
          row_d   = currentRow;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          byte_d  = 3'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        baud_d = baud_tc ? 16'd0 : baud_q + 16'd1;
        if (baud_tc) begin
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        baud_d = baud_tc ? 16'd0 : baud_q + 16'd1;
        if (baud_tc) begin
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        baud_d = baud_tc ? 16'd0 : baud_q + 16'd1;
        if (baud_tc) begin
          if (byte_q == last_byte) begin
            state_d = S_DONE;
          end else begin
            byte_d  = byte_q + 3'd1;
            state_d = S_START;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_q];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // All state and output registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      code_q  <= 2'd0;
      row_q   <= 9'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      code_q  <= code_d;
      row_q   <= row_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TX               = tx_q;
  assign busy             = busy_q;
  assign UARTsendComplete = done_q;

endmodule

// File: tb/tb_uart_result_sender.sv
// Bench for uart_result_sender: table vectors, random messages against a byte-level
// model, and hand-written sequences for injection, reset and back-to-back cases.
module tb_uart_result_sender;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] UARTsend;
  logic [8:0] currentRow;
  logic       TX;
  logic       busy;
  logic       UARTsendComplete;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_bytes[$];

  typedef struct {
    logic [1:0] code;
    logic [8:0] row;
    int         n;
    logic [7:0] b[6];
  } vec_t;

  vec_t vecs[5];

  uart_result_sender #(.CLKS_PER_BIT(CPB)) dut (
    .clock           (clock),
    .reset           (reset),
    .UARTsend        (UARTsend),
    .currentRow      (currentRow),
    .TX              (TX),
    .busy            (busy),
    .UARTsendComplete(UARTsendComplete)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the message is just a list of bytes derived from code and row.
  task automatic model(input int code, input int row);
    exp_bytes = {};
    if (code == 1) begin
      exp_bytes.push_back(8'h4D);
      exp_bytes.push_back(8'(48 + row / 100));
      exp_bytes.push_back(8'(48 + (row / 10) % 10));
      exp_bytes.push_back(8'(48 + row % 10));
    end else begin
      exp_bytes.push_back(8'h4E);
    end
    exp_bytes.push_back(8'h0D);
    exp_bytes.push_back(8'h0A);
  endtask

  task automatic set_vec(input int i, input logic [1:0] code, input logic [8:0] row, input int n,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    vecs[i].code = code; vecs[i].row = row; vecs[i].n = n;
    vecs[i].b[0] = b0; vecs[i].b[1] = b1; vecs[i].b[2] = b2;
    vecs[i].b[3] = b3; vecs[i].b[4] = b4; vecs[i].b[5] = b5;
  endtask

  task automatic idle_watch(input int n, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      if (TX !== 1'b1 || busy !== 1'b0 || UARTsendComplete !== 1'b0) bad++;
    end
    check(name, bad, 0);
  endtask

  // Sends one request and checks every cycle of TX/busy/complete against the
  // expected bit stream in exp_bytes, plus a mid-bit decode of the line.
  task automatic run_msg(input logic [1:0] code, input logic [8:0] row, input bit inject,
                         input bit immediate, input string tag);
    bit         bits[$];
    logic       rx[60];
    logic [7:0] rb;
    int total, wave_bad, pulses, pulse_at, frame_bad;
    bits = {};
    foreach (exp_bytes[i]) begin
      bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) bits.push_back(exp_bytes[i][k]);
      bits.push_back(1'b1);
    end
    total = bits.size() * CPB;
    if (!immediate) begin
      @(posedge clock); #1;
    end
    UARTsend   = code;
    currentRow = row;
    @(posedge clock); #1;
    UARTsend   = 2'd0;
    currentRow = 9'($urandom);
    check({tag, "_tx_at_accept"}, TX, 1);
    check({tag, "_busy_at_accept"}, busy, 0);
    wave_bad = 0; pulses = 0; pulse_at = -1;
    for (int c = 0; c < total + 2; c++) begin
      logic e_tx, e_busy, e_cmp;
      @(posedge clock); #1;
      e_tx   = (c < total) ? logic'(bits[c / CPB]) : 1'b1;
      e_busy = (c <= total);
      e_cmp  = (c == total);
      if (UARTsendComplete === 1'b1) begin
        pulses++;
        pulse_at = c;
      end
      if (TX !== e_tx || busy !== e_busy || UARTsendComplete !== e_cmp) wave_bad++;
      if (c < total && (c % CPB) == CPB / 2) rx[c / CPB] = TX;
      UARTsend = 2'd0;
      if (inject && c < total - 2 && (c % 37) == 5) begin
        UARTsend   = 2'($urandom_range(1, 3));
        currentRow = 9'($urandom);
      end
    end
    check({tag, "_wave_bad_cycles"}, wave_bad, 0);
    check({tag, "_complete_pulses"}, pulses, 1);
    check({tag, "_complete_cycle"}, pulse_at, total);
    frame_bad = 0;
    foreach (exp_bytes[i]) begin
      if (rx[i * 10] !== 1'b0 || rx[i * 10 + 9] !== 1'b1) frame_bad++;
      for (int k = 0; k < 8; k++) rb[k] = rx[i * 10 + 1 + k];
      check($sformatf("%s_byte%0d", tag, i), rb, exp_bytes[i]);
    end
    check({tag, "_framing_errors"}, frame_bad, 0);
  endtask

  initial begin
    reset      = 1'b1;
    UARTsend   = 2'd0;
    currentRow = 9'd0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_tx", TX, 1);
    check("reset_busy", busy, 0);
    check("reset_complete", UARTsendComplete, 0);
    reset = 1'b0;
    idle_watch(5, "idle_after_reset");

    set_vec(0, 2'd1, 9'd123, 6, 8'h4D, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A);
    set_vec(1, 2'd2, 9'd379, 3, 8'h4E, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00);
    set_vec(2, 2'd1, 9'd7,   6, 8'h4D, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A);
    set_vec(3, 2'd1, 9'd0,   6, 8'h4D, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A);
    set_vec(4, 2'd1, 9'd511, 6, 8'h4D, 8'h35, 8'h31, 8'h31, 8'h0D, 8'h0A);

    for (int v = 0; v < 5; v++) begin
      exp_bytes = {};
      for (int i = 0; i < vecs[v].n; i++) exp_bytes.push_back(vecs[v].b[i]);
      run_msg(vecs[v].code, vecs[v].row, 1'b0, 1'b0, $sformatf("vec%0d", v));
      idle_watch(3, $sformatf("vec%0d_idle", v));
    end

    for (int r = 0; r < 6; r++) begin
      int code, row;
      code = $urandom_range(1, 2);
      row  = $urandom_range(0, 511);
      model(code, row);
      run_msg(2'(code), 9'(row), 1'b0, 1'b0, $sformatf("rand%0d", r));
    end

    // Requests during a message and code 3 while idle change nothing.
    model(1, 245);
    run_msg(2'd1, 9'd245, 1'b1, 1'b0, "inject");
    idle_watch(20, "inject_no_extra");
    @(posedge clock); #1;
    UARTsend = 2'd3;
    @(posedge clock); #1;
    UARTsend = 2'd0;
    idle_watch(20, "code3_ignored");

    // Reset during the third byte's data bits abandons the message.
    @(posedge clock); #1;
    UARTsend   = 2'd1;
    currentRow = 9'd200;
    @(posedge clock); #1;
    UARTsend = 2'd0;
    repeat (23 * CPB + 2) @(posedge clock);
    #1;
    check("mid_reset_busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_reset_tx", TX, 1);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_complete", UARTsendComplete, 0);
    idle_watch(300, "mid_reset_quiet");
    model(2, 17);
    run_msg(2'd2, 9'd17, 1'b0, 1'b0, "after_reset");

    // Reset and request together: reset wins.
    @(posedge clock); #1;
    reset    = 1'b1;
    UARTsend = 2'd1;
    @(posedge clock); #1;
    reset    = 1'b0;
    UARTsend = 2'd0;
    idle_watch(10, "reset_beats_send");

    // Back-to-back: second request on the first idle cycle after completion.
    model(1, 88);
    run_msg(2'd1, 9'd88, 1'b0, 1'b0, "b2b_first");
    model(1, 402);
    run_msg(2'd1, 9'd402, 1'b0, 1'b1, "b2b_second");
    idle_watch(5, "b2b_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
